// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits
// that share one segment bus. Each digit is driven for ON_CYCLES clocks,
// separated by GAP_CYCLES clocks with every anode off so that the segment
// bus can settle without ghosting into the neighbouring digit.
//
// The value shown is double-buffered: a load strobe writes the pending
// register, and the pending contents are copied into the display register
// only on entry into digit 0. A whole frame therefore always comes from one
// value and an update can never tear across digits.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset
//   load         one-cycle strobe; captures value/dp_in into the pending buffer
//   value        hex nibbles, nibble k = value[4k+3:4k] = digit k (0 = LSD)
//   dp_in        per-digit decimal point, 1 = lit; buffered together with value
//   blank_mask   1 = digit k dark; applied live, not buffered
//   lz_en        leading-zero suppression enable; applied live
//   segs         {a,b,c,d,e,f,g} = segs[6:0], active-low
//   dp           decimal point, active-low
//   anodes       digit enables, active-low, at most one low at any time
//   frame_start  one-cycle pulse on the first ON cycle of digit 0
//   pending      1 = buffered value not yet committed to the display
//
// Handshake: load is a plain strobe with no back-pressure. Every cycle with
// load=1 is accepted; a later load before the commit overwrites an earlier one.
//
// All outputs are registered. The output comb process computes what the
// pins must show in the state being entered, so the registered pins line up
// with the state register and never glitch.
// -----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int NUM_DIGITS = 2,
    parameter int ON_CYCLES  = 2048,
    parameter int GAP_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic                      lz_en,
    output logic [6:0]                segs,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     anodes,
    output logic                      frame_start,
    output logic                      pending
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int VAL_W   = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_GAP = 1'b0,
        ST_ON  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Scan FSM state
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;

    // ------------------------------------------------------------------
    // Buffers
    // ------------------------------------------------------------------
    logic [VAL_W-1:0]      disp_val;
    logic [VAL_W-1:0]      disp_val_next;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic [NUM_DIGITS-1:0] disp_dp_next;
    logic [VAL_W-1:0]      pend_val;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic                  pending_next;

    logic enter_d0;
    logic commit;

    // ------------------------------------------------------------------
    // Output staging
    // ------------------------------------------------------------------
    logic [6:0]            segs_next;
    logic                  dp_next;
    logic [NUM_DIGITS-1:0] anodes_next;
    logic                  frame_start_next;
    logic [NUM_DIGITS-1:0] suppressed;
    logic                  run_zero;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_dark;

    // Hex nibble to active-low {a,b,c,d,e,f,g}.
    function automatic logic [6:0] hex_to_segs(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0001100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            4'hF:    s = 7'b0111000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_GAP;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // idx already points at the next digit while in GAP, so the digit to
    // be lit is known before the ON phase begins.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        idx_next   = idx;
        case (state)
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_next = ST_ON;
                    cnt_next   = '0;
                end
            end
            ST_ON: begin
                if (cnt == ON_LAST) begin
                    state_next = ST_GAP;
                    cnt_next   = '0;
                    idx_next   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end
            end
            default: begin
                state_next = ST_GAP;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase
    end

    // Entry into digit 0 is the only point where the display may change.
    assign enter_d0 = (state == ST_GAP) && (cnt == GAP_LAST) && (idx == '0);
    assign commit   = enter_d0 && pending;

    // ------------------------------------------------------------------
    // Buffer next values. A load on the commit cycle lands in the pending
    // register while the older pending data moves to the display, so
    // pending stays set for the following frame.
    // ------------------------------------------------------------------
    always_comb begin
        disp_val_next = commit ? pend_val : disp_val;
        disp_dp_next  = commit ? pend_dp  : disp_dp;
        if (load) begin
            pending_next = 1'b1;
        end else if (commit) begin
            pending_next = 1'b0;
        end else begin
            pending_next = pending;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            disp_val <= '0;
            disp_dp  <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            pending  <= 1'b0;
        end else begin
            disp_val <= disp_val_next;
            disp_dp  <= disp_dp_next;
            pending  <= pending_next;
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero suppression: walk from the most significant digit down,
    // tracking whether every nibble seen so far is zero. Digit 0 is always
    // shown so a zero value still displays "0".
    // ------------------------------------------------------------------
    always_comb begin
        suppressed = '0;
        run_zero   = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run_zero      = run_zero && (disp_val_next[4*k +: 4] == 4'h0);
            suppressed[k] = lz_en && run_zero && (k > 0);
        end
    end

    // ------------------------------------------------------------------
    // FSM process 3: output logic for the state being entered.
    // Blanked or suppressed digits keep their anode low so the scan
    // timing and brightness of the other digits are unaffected.
    // ------------------------------------------------------------------
    always_comb begin
        segs_next        = 7'h7F;
        dp_next          = 1'b1;
        anodes_next      = '1;
        frame_start_next = enter_d0;
        cur_nib          = 4'h0;
        cur_dp           = 1'b0;
        cur_dark         = 1'b1;
        if (state_next == ST_ON) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_next == IDX_W'(k)) begin
                    anodes_next[k] = 1'b0;
                    cur_nib        = disp_val_next[4*k +: 4];
                    cur_dp         = disp_dp_next[k];
                    cur_dark       = blank_mask[k] || suppressed[k];
                end
            end
            if (!cur_dark) begin
                segs_next = hex_to_segs(cur_nib);
                dp_next   = ~cur_dp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            segs        <= 7'h7F;
            dp          <= 1'b1;
            anodes      <= '1;
            frame_start <= 1'b0;
        end else begin
            segs        <= segs_next;
            dp          <= dp_next;
            anodes      <= anodes_next;
            frame_start <= frame_start_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Directed bench for seg_scan_driver with NUM_DIGITS=2, ON_CYCLES=4,
// GAP_CYCLES=1 (frame = 10 cycles). Inputs change and outputs are sampled
// on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int ND  = 2;
    localparam int ONC = 4;
    localparam int GPC = 1;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          load;
    logic [7:0]    value;
    logic [1:0]    dp_in;
    logic [1:0]    blank_mask;
    logic          lz_en;
    logic [6:0]    segs;
    logic          dp;
    logic [1:0]    anodes;
    logic          frame_start;
    logic          pending;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS (ND),
        .ON_CYCLES  (ONC),
        .GAP_CYCLES (GPC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .value       (value),
        .dp_in       (dp_in),
        .blank_mask  (blank_mask),
        .lz_en       (lz_en),
        .segs        (segs),
        .dp          (dp),
        .anodes      (anodes),
        .frame_start (frame_start),
        .pending     (pending)
    );

    // ---------------- driver tasks ----------------
    // Advance to the next falling edge; load is a one-cycle strobe so it is
    // dropped once the rising edge has sampled it.
    task automatic step();
        @(negedge clk);
        load = 1'b0;
    endtask

    // Check all pins for the current cycle, then advance one cycle.
    task automatic chk(input string tag, input logic [1:0] ea, input logic [6:0] es,
                       input logic ed, input logic ef);
        checks++;
        assert (anodes === ea) else begin
            errors++;
            $error("FAIL %s anodes got=%b exp=%b", tag, anodes, ea);
        end
        checks++;
        assert (segs === es) else begin
            errors++;
            $error("FAIL %s segs got=%b exp=%b", tag, segs, es);
        end
        checks++;
        assert (dp === ed) else begin
            errors++;
            $error("FAIL %s dp got=%b exp=%b", tag, dp, ed);
        end
        checks++;
        assert (frame_start === ef) else begin
            errors++;
            $error("FAIL %s frame_start got=%b exp=%b", tag, frame_start, ef);
        end
        step();
    endtask

    task automatic chk_pend(input string tag, input logic ep);
        checks++;
        assert (pending === ep) else begin
            errors++;
            $error("FAIL %s pending got=%b exp=%b", tag, pending, ep);
        end
    endtask

    task automatic gap(input string tag);
        chk({tag, "_gap"}, 2'b11, 7'h7F, 1'b1, 1'b0);
    endtask

    // One ON phase of digit k; optional loads on its first/second cycle.
    task automatic on_phase(input string tag, input int k, input logic [6:0] es,
                            input logic ed, input int nld,
                            input logic [7:0] va, input logic [7:0] vb);
        for (int i = 0; i < ONC; i++) begin
            if (i == 0 && nld >= 1) begin
                value = va;
                load  = 1'b1;
            end
            if (i == 1 && nld >= 2) begin
                value = vb;
                load  = 1'b1;
            end
            chk($sformatf("%s_d%0d_c%0d", tag, k, i), (k == 0) ? 2'b10 : 2'b01,
                es, ed, (k == 0 && i == 0));
        end
    endtask

    // One whole frame starting at the gap before digit 0.
    // lg: load vg on the commit edge; nld/va/vb: loads during digit 1.
    task automatic frame(input string tag, input logic pend0,
                         input logic [6:0] s0, input logic d0,
                         input logic [6:0] s1, input logic d1,
                         input logic lg, input logic [7:0] vg,
                         input int nld, input logic [7:0] va, input logic [7:0] vb);
        if (lg) begin
            value = vg;
            load  = 1'b1;
        end
        gap(tag);
        chk_pend({tag, "_pend"}, pend0);
        on_phase(tag, 0, s0, d0, 0, 8'h00, 8'h00);
        gap(tag);
        on_phase(tag, 1, s1, d1, nld, va, vb);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset      = 1'b0;
        load       = 1'b0;
        value      = 8'h00;
        dp_in      = 2'b00;
        blank_mask = 2'b00;
        lz_en      = 1'b0;

        // Reset held for three rising edges.
        step();
        step();
        gap("rst");
        chk_pend("rst_pend", 1'b0);
        reset = 1'b1;

        // Boot frame shows 00; load A5 / dp 01 during digit 1.
        dp_in = 2'b01;
        frame("f1", 1'b0, 7'h01, 1'b1, 7'h01, 1'b1, 1'b0, 8'h00, 1, 8'hA5, 8'h00);
        chk_pend("f1_end", 1'b1);
        dp_in = 2'b00;

        // A5 committed: digit 0 "5" with dp lit, digit 1 "A" with dp dark.
        frame("f2", 1'b0, 7'h24, 1'b0, 7'h08, 1'b1, 1'b0, 8'h00, 1, 8'h07, 8'h00);
        lz_en = 1'b1;

        // 07 with suppression: digit 1 dark, anode still asserted.
        frame("f3", 1'b0, 7'h0F, 1'b1, 7'h7F, 1'b1, 1'b0, 8'h00, 1, 8'h00, 8'h00);
        // 00: digit 0 still shows "0".
        frame("f4", 1'b0, 7'h01, 1'b1, 7'h7F, 1'b1, 1'b0, 8'h00, 1, 8'h30, 8'h00);
        // 30: both lit; then two loads 11, 22 before the commit.
        frame("f5", 1'b0, 7'h01, 1'b1, 7'h06, 1'b1, 1'b0, 8'h00, 2, 8'h11, 8'h22);
        chk_pend("f5_end", 1'b1);
        // Last write wins (22); load of 33 on the commit edge keeps pending.
        frame("f6", 1'b1, 7'h12, 1'b1, 7'h12, 1'b1, 1'b1, 8'h33, 0, 8'h00, 8'h00);
        // 33 now shown; load FF.
        frame("f7", 1'b0, 7'h06, 1'b1, 7'h06, 1'b1, 1'b0, 8'h00, 1, 8'hFF, 8'h00);

        // Live blanking of digit 1.
        blank_mask = 2'b10;
        frame("f8", 1'b0, 7'h38, 1'b1, 7'h7F, 1'b1, 1'b0, 8'h00, 0, 8'h00, 8'h00);
        blank_mask = 2'b00;

        // Reset in the middle of digit 1 ON with pending data.
        gap("f9");
        on_phase("f9", 0, 7'h38, 1'b1, 0, 8'h00, 8'h00);
        gap("f9b");
        value = 8'h44;
        load  = 1'b1;
        chk("f9_d1_c0", 2'b01, 7'h38, 1'b1, 1'b0);
        chk_pend("f9_pend", 1'b1);
        reset = 1'b0;
        chk("f9_d1_c1", 2'b01, 7'h38, 1'b1, 1'b0);
        chk_pend("mid_rst_pend", 1'b0);
        gap("mid_rst");
        reset = 1'b1;

        // Display reverted to 0 and the discarded 44 never appears.
        frame("post", 1'b0, 7'h01, 1'b1, 7'h7F, 1'b1, 1'b0, 8'h00, 0, 8'h00, 8'h00);
        chk_pend("post_end", 1'b0);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
